// File: rtl/spi_cfg_master_if.sv
// Request/status bundle for spi_cfg_master.
//   req_valid/req_addr/req_data/req_ready : host register-write request handshake
//   cs/sclk/copi                          : SPI pins (cs active-low, sclk idle low)
//   busy/frames_sent                      : status
// Modport master is the block's view (it drives the SPI pins); slave is the
// host/peripheral view.
interface spi_cfg_master_if;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_ready;
  logic              cs;
  logic              sclk;
  logic              copi;
  logic              busy;
  logic [7:0]        frames_sent;

  modport master (
    input  req_valid, req_addr, req_data,
    output req_ready, cs, sclk, copi, busy, frames_sent
  );

  modport slave (
    output req_valid, req_addr, req_data,
    input  req_ready, cs, sclk, copi, busy, frames_sent
  );
endinterface

// File: rtl/spi_cfg_master.sv
// SPI configuration-write master.
// Queues 7-bit address / 8-bit data write requests in a FIFO and sends each as
// a 16-bit SPI frame, MSB first: {1'b1 (write), addr[6:0], data[7:0]}.
// Frame sequence: IDLE -> SETUP -> SHIFT (16 bits) -> HOLD -> GAP -> IDLE,
// 36*CLK_DIV cycles from leaving IDLE to returning.
// Ports:
//   clk  : system clock, all state on posedge
//   rst  : asynchronous active-low reset
//   bus  : spi_cfg_master_if.master (request handshake, SPI pins, status)
// Parameters: CLK_DIV (sclk half-period, 2..255), FIFO_DEPTH (power of two).
// Optional build macro SPI_CFG_BOOT_INIT_EN: after reset, five fixed init
// frames are sent before host requests are accepted.
module spi_cfg_master #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  spi_cfg_master_if.master bus
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CNT_W   = 9;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned USED_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  FULL_LAST  = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  HIGH_START = CNT_W'(CLK_DIV);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(FRAME_W - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [USED_W-1:0] USED_FULL  = USED_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } req_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [FRAME_W-1:0]   sh_q, sh_d;
  logic [7:0]           fs_q, fs_d;
  logic                 cs_q, cs_d;
  logic                 sclk_q, sclk_d;
  logic                 copi_q, copi_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [USED_W-1:0]    used_q, used_d;
  logic                 push_c;
  logic                 pop_c;
  req_t                 mem_q [FIFO_DEPTH];

`ifdef SPI_CFG_BOOT_INIT_EN
  localparam int unsigned BOOT_N = 5;
  logic [2:0] boot_idx_q, boot_idx_d;
  logic       boot_done_q, boot_done_d;

  // Fixed power-up register writes, in send order.
  function automatic logic [FRAME_W-1:0] boot_frame(input logic [2:0] idx);
    case (idx)
      3'd0:    boot_frame = 16'h80FF;
      3'd1:    boot_frame = 16'h81FF;
      3'd2:    boot_frame = 16'h8200;
      3'd3:    boot_frame = 16'h8300;
      default: boot_frame = 16'h8480;
    endcase
  endfunction
`endif

  // Host push; req_ready is registered from the occupancy, so a full queue
  // refuses a push even in a cycle where the head is being popped.
  assign push_c = bus.req_valid & ready_q;

  // Queue storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= req_t'({bus.req_addr, bus.req_data});
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      fs_q     <= '0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      copi_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
`ifdef SPI_CFG_BOOT_INIT_EN
      boot_idx_q  <= '0;
      boot_done_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      fs_q     <= fs_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      copi_q   <= copi_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
`ifdef SPI_CFG_BOOT_INIT_EN
      boot_idx_q  <= boot_idx_d;
      boot_done_q <= boot_done_d;
`endif
    end
  end

  // Next-state, queue bookkeeping and pin values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    fs_d     = fs_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    used_d   = used_q;
    pop_c    = 1'b0;
`ifdef SPI_CFG_BOOT_INIT_EN
    boot_idx_d  = boot_idx_q;
    boot_done_d = boot_done_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef SPI_CFG_BOOT_INIT_EN
        if (!boot_done_q) begin
          if (boot_idx_q < 3'(BOOT_N)) begin
            sh_d       = boot_frame(boot_idx_q);
            boot_idx_d = boot_idx_q + 3'd1;
            state_d    = SETUP;
            cnt_d      = '0;
          end
        end else
`endif
        if (used_q != '0) begin
          pop_c   = 1'b1;
          sh_d    = {1'b1, mem_q[rd_ptr_q]};
          state_d = SETUP;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == HALF_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        // Shift at the end of each bit so copi only moves with sclk low.
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          sh_d  = {sh_q[FRAME_W-2:0], 1'b0};
          if (bit_q == BIT_LAST) begin
            state_d = HOLD;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == HALF_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          fs_d    = fs_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == FULL_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
`ifdef SPI_CFG_BOOT_INIT_EN
          if (boot_idx_q == 3'(BOOT_N)) begin
            boot_done_d = 1'b1;
          end
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (push_c) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   used_d = used_q + USED_W'(1);
      2'b01:   used_d = used_q - USED_W'(1);
      default: used_d = used_q;
    endcase

    // Pins follow the current state one cycle later (pop cycle, then pins).
    cs_d    = !((state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD));
    sclk_d  = (state_q == SHIFT) && (cnt_q >= HIGH_START);
    copi_d  = ((state_q == SETUP) || (state_q == SHIFT)) && sh_q[FRAME_W-1];

    ready_d = (used_d != USED_FULL);
    busy_d  = (state_d != IDLE) || (used_d != '0);
`ifdef SPI_CFG_BOOT_INIT_EN
    ready_d = ready_d && boot_done_d;
    busy_d  = busy_d || !boot_done_d;
`endif
  end

  assign bus.req_ready   = ready_q;
  assign bus.cs          = cs_q;
  assign bus.sclk        = sclk_q;
  assign bus.copi        = copi_q;
  assign bus.busy        = busy_q;
  assign bus.frames_sent = fs_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Self-checking bench for spi_cfg_master: table of single-frame vectors,
// back-to-back/full-queue sequence, mid-frame reset, and 256 random frames
// (frames_sent wrap) checked against a frame-level reference model and an
// SPI peripheral model. Handles the SPI_CFG_BOOT_INIT_EN build as well.
module tb_spi_cfg_master;
  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CS_LOW_CYC = 34 * CLK_DIV;
  localparam int unsigned FRAME_CYC  = 36 * CLK_DIV + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_cfg_master_if bus();

  spi_cfg_master #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    int          bits;
    int          low;
  } cap_t;

  typedef struct {
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] word;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          exp_fs = 0;
  logic [15:0] exp_q[$];
  cap_t        cap_q[$];
  int          gap_q[$];
  logic [7:0]  regs [128];

  // SPI peripheral model / pin monitor, sampled on the falling clk edge.
  int          sclk_rises = 0;
  int          sclk_outside = 0;
  int          mon_bits = 0;
  int          mon_low = 0;
  int          mon_high = 0;
  bit          mon_had = 1'b0;
  logic        mon_psclk = 1'b0;
  logic        mon_pcs = 1'b1;
  logic [15:0] mon_sh = '0;

  always @(negedge clk) begin
    if (!rst) begin
      mon_bits = 0; mon_low = 0; mon_high = 0; mon_had = 1'b0;
      mon_psclk = 1'b0; mon_pcs = 1'b1;
    end else begin
      if (bus.sclk && !mon_psclk) begin
        sclk_rises++;
        if (bus.cs) sclk_outside++;
        else begin
          mon_sh = {mon_sh[14:0], bus.copi};
          mon_bits++;
        end
      end
      if (bus.cs) begin
        if (!mon_pcs) begin
          cap_q.push_back('{mon_sh, mon_bits, mon_low});
          if (mon_bits == 16) regs[mon_sh[14:8]] = mon_sh[7:0];
          mon_bits = 0; mon_low = 0; mon_high = 1; mon_had = 1'b1;
        end else mon_high++;
      end else begin
        if (mon_pcs && mon_had) gap_q.push_back(mon_high);
        mon_low++;
      end
      mon_psclk = bus.sclk;
      mon_pcs   = bus.cs;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((bus.busy || !bus.cs) && k < budget);
    if (bus.busy || !bus.cs) timeout(name);
  endtask

  // Offer one request; returns after the accepting edge, then scrambles the bus.
  task automatic push(input logic [6:0] a, input logic [7:0] d);
    int k;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_data = d;
    k = 0;
    while (!bus.req_ready && k < 100 * CLK_DIV) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready) begin
      timeout("push_ready");
      bus.req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      exp_q.push_back({1'b1, a, d});
      bus.req_valid = 1'b0;
      bus.req_addr  = 7'($urandom);
      bus.req_data  = 8'($urandom);
    end
  endtask

  task automatic compare_frames(input string tag);
    cap_t        c;
    logic [15:0] e;
    check({tag, "_count"}, cap_q.size(), exp_q.size());
    while (cap_q.size() > 0 && exp_q.size() > 0) begin
      c = cap_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_word"}, c.word, e);
      check({tag, "_bits"}, c.bits, 16);
      check({tag, "_cs_low"}, c.low, CS_LOW_CYC);
      exp_fs++;
    end
    cap_q.delete();
    exp_q.delete();
    foreach (gap_q[i]) check({tag, "_gap_ok"}, gap_q[i] >= 2 * CLK_DIV, 1);
    gap_q.delete();
    check({tag, "_frames_sent"}, bus.frames_sent, 8'(exp_fs));
  endtask

  task automatic do_reset();
    int k;
    int early;
    logic [15:0] boot_exp [5];
    cap_t c;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs", bus.cs, 1);
    check("rst_sclk", bus.sclk, 0);
    check("rst_copi", bus.copi, 0);
    check("rst_frames", bus.frames_sent, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.req_ready, 0);
    exp_q.delete(); cap_q.delete(); gap_q.delete();
    exp_fs = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
`ifndef SPI_CFG_BOOT_INIT_EN
    check("ready_after_release", bus.req_ready, 1);
`else
    check("ready_after_release", bus.req_ready, 0);
    boot_exp = '{16'h80FF, 16'h81FF, 16'h8200, 16'h8300, 16'h8480};
    k = 0; early = 0;
    while ((cap_q.size() < 5 || !bus.req_ready) && k < 6 * FRAME_CYC) begin
      @(negedge clk);
      if (bus.req_ready && cap_q.size() < 5) early++;
      k++;
    end
    if (k >= 6 * FRAME_CYC) timeout("boot_done");
    check("boot_ready_low", early, 0);
    check("boot_count", cap_q.size(), 5);
    for (int i = 0; i < 5 && cap_q.size() > 0; i++) begin
      c = cap_q.pop_front();
      check("boot_word", c.word, boot_exp[i]);
    end
    check("boot_frames_sent", bus.frames_sent, 5);
    exp_fs = 5;
    cap_q.delete(); gap_q.delete();
`endif
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    cap_t c;
    bit   exp_ready [5];
    int   k;
    int   r0;
    int   base_fs;

    vecs[0] = '{7'h04, 8'hA5, 16'h84A5};
    vecs[1] = '{7'h00, 8'h00, 16'h8000};
    vecs[2] = '{7'h7F, 8'hFF, 16'hFFFF};
    vecs[3] = '{7'h55, 8'h3C, 16'hD53C};
    vecs[4] = '{7'h2A, 8'h81, 16'hAA81};
    vecs[5] = '{7'h01, 8'hC3, 16'h81C3};
    vecs[6] = '{7'h02, 8'h5A, 16'h825A};
    vecs[7] = '{7'h03, 8'h0F, 16'h830F};
    exp_ready = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    #2;
    do_reset();

    // Single frames from idle: latency, word on the pins, cs-low length.
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].addr, vecs[i].data);
      @(posedge clk); #1;
      check("cs_before_fall", bus.cs, 1);
      @(posedge clk); #1;
      check("cs_fall_latency", bus.cs, 0);
      wait_idle("vec_idle", 2 * FRAME_CYC);
      check("vec_count", cap_q.size(), 1);
      if (cap_q.size() > 0) begin
        c = cap_q.pop_front();
        check("vec_word", c.word, vecs[i].word);
        check("vec_bits", c.bits, 16);
        check("vec_cs_low", c.low, CS_LOW_CYC);
      end
      cap_q.delete(); exp_q.delete(); gap_q.delete();
      exp_fs++;
      check("vec_frames_sent", bus.frames_sent, 8'(exp_fs));
    end
    check("periph_reg0", regs[0], 8'h00);
    check("periph_reg1", regs[1], 8'hC3);
    check("periph_reg2", regs[2], 8'h5A);
    check("periph_reg3", regs[3], 8'h0F);
    check("periph_reg4", regs[4], 8'hA5);

    // Fill the queue while a frame is in flight; 5th offer waits for a pop.
    push(7'h10, 8'h01);
    k = 0;
    while (bus.cs && k < 10) begin @(negedge clk); k++; end
    if (bus.cs) timeout("prime_cs_low");
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 7'(8'h20 + 8'(i));
      bus.req_data  = 8'($urandom);
      check("fill_ready", bus.req_ready, exp_ready[i]);
      if (bus.req_ready) exp_q.push_back({1'b1, bus.req_addr, bus.req_data});
      if (i < 4) @(negedge clk);
    end
    k = 0;
    while (!bus.req_ready && k < 2 * FRAME_CYC) begin @(negedge clk); k++; end
    if (!bus.req_ready) timeout("fill_ready_return");
    else begin
      check("fill_prime_done", cap_q.size(), 1);
      exp_q.push_back({1'b1, bus.req_addr, bus.req_data});
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    wait_idle("fill_idle", 8 * FRAME_CYC);
    compare_frames("fill");

    // Reset at the 7th sclk rise with two entries queued.
    push(7'h11, 8'h22);
    push(7'h33, 8'h44);
    push(7'h55, 8'h66);
    r0 = sclk_rises;
    k = 0;
    while (sclk_rises < r0 + 7 && k < 2 * FRAME_CYC) begin @(negedge clk); k++; end
    if (sclk_rises < r0 + 7) timeout("midrst_sclk");
    #1;
    rst = 1'b0;
    #1;
    check("midrst_cs", bus.cs, 1);
    check("midrst_sclk", bus.sclk, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_frames", bus.frames_sent, 0);
    do_reset();
    r0 = sclk_rises;
    repeat (2 * FRAME_CYC) @(negedge clk);
    check("midrst_no_sclk", sclk_rises - r0, 0);
    check("midrst_no_frames", cap_q.size(), 0);
    check("midrst_busy_after", bus.busy, 0);
    check("midrst_frames_after", bus.frames_sent, 8'(exp_fs));

    // 256 random frames: ordering, timing and frames_sent wrap.
    base_fs = exp_fs;
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      push(7'($urandom), 8'($urandom));
    end
    wait_idle("rand_idle", 6 * FRAME_CYC);
    compare_frames("rand");
    check("wrap_frames_sent", bus.frames_sent, 8'(base_fs));
    check("sclk_outside_cs", sclk_outside, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_cfg_master.md
SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 4: request queue entries; power of two.
REQ-003 clk  input  1  system clock; all state on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  host presents a register-write request.
REQ-006 req_addr  input  7  target register address.
REQ-007 req_data  input  8  target register data.
REQ-008 req_ready  output  1  queue can accept; a push occurs on req_valid && req_ready at posedge clk.
REQ-009 cs  output  1  SPI chip select, active-low, registered.
REQ-010 sclk  output  1  SPI clock, idle low, registered.
REQ-011 copi  output  1  SPI serial data, registered.
REQ-012 busy  output  1  high when the FSM is not in IDLE or the queue is non-empty.
REQ-013 frames_sent  output  8  count of completed frames.

Function
REQ-014 The block SHALL queue requests in a FIFO_DEPTH-entry FIFO and serialise each one as a 16-bit frame, MSB first: bit15 = 1 (write), bits14:8 = req_addr, bits7:0 = req_data.
REQ-015 req_ready SHALL equal !full; if the queue is full, a push is refused even when a pop occurs in the same cycle.
REQ-016 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD and GAP.
- IDLE -> SETUP when the queue is non-empty; pop the head entry into the shift register in that same cycle.
REQ-017 SETUP: cs=0, sclk=0, copi=frame bit15, held for CLK_DIV cycles -> SHIFT.
REQ-018 SHIFT: each bit lasts 2*CLK_DIV cycles, sclk low for the first CLK_DIV cycles and high for the second; copi changes only at the start of a bit period (sclk low); after the 16th high phase -> HOLD.
REQ-019 HOLD: cs=0, sclk=0, held for CLK_DIV cycles -> GAP; frames_sent increments on entry to GAP and wraps 255 -> 0.
REQ-020 GAP: cs=1, sclk=0, copi=0, held for 2*CLK_DIV cycles -> IDLE; back-to-back frames therefore have at least 2*CLK_DIV cycles with cs high.
REQ-021 Total frame time from leaving IDLE to re-entering IDLE SHALL be exactly 36*CLK_DIV cycles.
REQ-022 Exactly 16 sclk rising edges SHALL occur per frame, all while cs=0.
REQ-023 A push into an empty queue while in IDLE SHALL cause cs to fall 2 clk cycles after the push edge (the pop cycle, then the registered output).
REQ-024 req_addr/req_data changes after the push edge SHALL NOT affect queued frames.

Reset
REQ-025 While rst=0: cs=1, sclk=0, copi=0, frames_sent=0, FSM=IDLE, queue empty, busy=0, req_ready=0.
REQ-026 Reset asserted mid-frame SHALL force cs high immediately (asynchronously) and discard the frame in flight and all queued entries; no partial frame is resumed.
REQ-027 req_ready SHALL rise on the first clk edge after reset release, unless BOOT_INIT_EN holds it low.

Configuration
REQ-028 Macro SPI_CFG_BOOT_INIT_EN, when defined:
- After reset release, the block automatically sends five frames before any host request: (0x00,0xFF), (0x01,0xFF), (0x02,0x00), (0x03,0x00), (0x04,0x80).
- req_ready is held 0 and busy is held 1 until the fifth frame's GAP completes.
- The five frames are counted in frames_sent.
REQ-029 When SPI_CFG_BOOT_INIT_EN is not defined, no init frames are sent, and the block is idle with req_ready=1 after reset.

Verification
REQ-030 CLK_DIV=4, push (0x04,0xA5) -> cs low for 136 cycles, copi bits 1000_0100_1010_0101 sampled on the 16 sclk rises, frames_sent=1.
REQ-031 Push 5 requests back-to-back in consecutive cycles -> first 4 accepted, req_ready=0 on the 5th until the first pop, all 5 frames emitted in order with a cs-high gap >= 8 cycles between frames.
REQ-032 Assert rst at the 7th sclk rise of a frame with 2 entries queued -> cs=1 immediately, no further sclk edges, busy=0, frames_sent=0 after release.
REQ-033 256 frames -> frames_sent wraps to 0.
REQ-034 With SPI_CFG_BOOT_INIT_EN defined -> five init frames observed on the SPI pins, req_ready=0 throughout, then req_ready=1 and frames_sent=5.
REQ-035 Frames sent to the SPI peripheral model at CLK_DIV=2 (minimum) -> addressed registers 0x00..0x04 hold the written data.
